spi_reg_bridge: RTL and testbench

//  System-clock controller behind spi_slave_param_mode0. Synchronizes the slave's

---
 rtl/spi_reg_bridge.sv | 143 ++++++++++++++
 tb/tb_spi_reg_bridge.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - system-clock register bank bridge behind an SPI mode-0 slave
module spi_reg_bridge #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          spi_done,
    input  logic                          spi_we,
    input  logic [ADDR_BITS-1:0]          spi_addr,
    input  logic [DATA_BITS-1:0]          spi_wdata,
    output logic [DATA_BITS-1:0]          spi_rdata,
    input  logic                          core_req,
    input  logic [ADDR_BITS-1:0]          core_addr,
    input  logic [DATA_BITS-1:0]          core_wdata,
    output logic                          core_gnt,
    output logic [NUM_REGS*DATA_BITS-1:0] regs_flat,
    output logic [7:0]                    frame_cnt,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int IDX_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_BITS-1:0] NUM_REGS_A = ADDR_BITS'(NUM_REGS);

    typedef enum logic {IDLE, COMMIT} state_t;
    typedef enum logic {PRIO_CORE, PRIO_SPI} prio_t;

    state_t state, state_next;
    prio_t  prio, prio_next;

    logic [1:0]           done_sync;
    logic [1:0]           we_sync;
    logic                 done_prev;
    logic                 done_rise;
    logic                 capture;
    logic                 drop;
    logic                 spi_grant;
    logic [ADDR_BITS-1:0] cap_addr;
    logic [DATA_BITS-1:0] cap_wdata;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [DATA_BITS-1:0] regs [NUM_REGS];

    assign done_rise = done_sync[1] & ~done_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_sync <= '0;
            we_sync   <= '0;
            done_prev <= 1'b0;
        end else begin
            done_sync <= {done_sync[0], spi_done};
            we_sync   <= {we_sync[0], spi_we};
            done_prev <= done_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= PRIO_CORE;
        end else begin
            state <= state_next;
            prio  <= prio_next;
        end
    end

    // A pending SPI write yields to the core at most once, then takes priority.
    always_comb begin
        state_next = state;
        prio_next  = prio;
        capture    = 1'b0;
        drop       = 1'b0;
        spi_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (done_rise) begin
                    capture = 1'b1;
                    if (we_sync[1]) begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (!core_req || prio == PRIO_SPI) begin
                    spi_grant  = 1'b1;
                    prio_next  = PRIO_CORE;
                    state_next = IDLE;
                end else begin
                    prio_next = PRIO_SPI;
                end
                drop = done_rise;
            end
            default: state_next = IDLE;
        endcase
    end

    assign core_gnt = core_req & ~spi_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            ovf       <= 1'b0;
            spi_rdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (capture) begin
                cap_addr  <= spi_addr;
                cap_wdata <= spi_wdata;
                rd_ptr    <= spi_addr;
            end
            if (capture || drop) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (spi_grant) begin
                if (cap_addr < NUM_REGS_A) begin
                    regs[cap_addr[IDX_BITS-1:0]] <= cap_wdata;
                end
            end else if (core_gnt) begin
                if (core_addr < NUM_REGS_A) begin
                    regs[core_addr[IDX_BITS-1:0]] <= core_wdata;
                end
            end
            spi_rdata <= (rd_ptr < NUM_REGS_A) ? regs[rd_ptr[IDX_BITS-1:0]] : '0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_BITS +: DATA_BITS] = regs[g];
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - directed self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         spi_done;
    logic         spi_we;
    logic [6:0]   spi_addr;
    logic [7:0]   spi_wdata;
    logic [7:0]   spi_rdata;
    logic         core_req;
    logic [6:0]   core_addr;
    logic [7:0]   core_wdata;
    logic         core_gnt;
    logic [127:0] regs_flat;
    logic [7:0]   frame_cnt;
    logic         ovf;
    logic         ovf_clr;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_regs [16];

    spi_reg_bridge #(.ADDR_BITS(7), .DATA_BITS(8), .NUM_REGS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_done   (spi_done),
        .spi_we     (spi_we),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_rdata  (spi_rdata),
        .core_req   (core_req),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .regs_flat  (regs_flat),
        .frame_cnt  (frame_cnt),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_flat();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) begin
            v[i*8 +: 8] = exp_regs[i];
        end
        return v;
    endfunction

    task automatic start_frame(input logic [6:0] a, input logic [7:0] d, input logic w);
        spi_addr  = a;
        spi_wdata = d;
        spi_we    = w;
        spi_done  = 1'b1;
    endtask

    task automatic end_frame();
        spi_done = 1'b0;
        tick(3);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        rst_n = 1'b0; spi_done = 1'b0; spi_we = 1'b0; spi_addr = '0; spi_wdata = '0;
        core_req = 1'b0; core_addr = '0; core_wdata = '0; ovf_clr = 1'b0;
        tick(2);
        chk("rst_regs", regs_flat, 128'h0);
        chk("rst_rdata", spi_rdata, 8'h00);
        chk("rst_cnt", frame_cnt, 8'h00);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_gnt", core_gnt, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // uncontended write: visible exactly 4 clocks after done rises
        start_frame(7'd3, 8'hA5, 1'b1);
        tick(3);
        chk("w1_cnt", frame_cnt, 8'd1);
        chk("w1_not_yet", regs_flat, exp_flat());
        tick(1);
        exp_regs[3] = 8'hA5;
        chk("w1_reg3", regs_flat, exp_flat());
        end_frame();

        // read frames: rdata follows the last captured address
        start_frame(7'd5, 8'h00, 1'b0);
        tick(4);
        chk("rd5_rdata", spi_rdata, 8'h00);
        end_frame();
        start_frame(7'd3, 8'hFF, 1'b0);
        tick(4);
        chk("rd3_rdata", spi_rdata, 8'hA5);
        chk("rd3_bank", regs_flat, exp_flat());
        end_frame();
        chk("rd_cnt", frame_cnt, 8'd3);

        // contention: core first, SPI next cycle
        start_frame(7'd4, 8'h5A, 1'b1);
        tick(3);
        core_req = 1'b1; core_addr = 7'd7; core_wdata = 8'h3C;
        #1 chk("c_gnt_first", core_gnt, 1'b1);
        tick(1);
        exp_regs[7] = 8'h3C;
        chk("c_core_wr", regs_flat, exp_flat());
        chk("c_gnt_low", core_gnt, 1'b0);
        tick(1);
        exp_regs[4] = 8'h5A;
        chk("c_spi_wr", regs_flat, exp_flat());
        chk("c_gnt_idle", core_gnt, 1'b1);
        core_req = 1'b0;
        end_frame();

        // unmapped address: write discarded, read returns 0
        start_frame(7'd20, 8'hEE, 1'b1);
        tick(4);
        chk("um_rdata", spi_rdata, 8'h00);
        chk("um_bank", regs_flat, exp_flat());
        end_frame();
        core_req = 1'b1; core_addr = 7'd20; core_wdata = 8'h11;
        #1 chk("um_core_gnt", core_gnt, 1'b1);
        tick(1);
        core_req = 1'b0;
        chk("um_core_bank", regs_flat, exp_flat());
        chk("um_cnt", frame_cnt, 8'd5);

        // second frame arrives while the first is still waiting to commit
        start_frame(7'd8, 8'h11, 1'b1);
        tick(1);
        spi_done = 1'b0;
        tick(1);
        spi_done = 1'b1;
        tick(1);
        spi_addr = 7'd9; spi_wdata = 8'h22;
        core_req = 1'b1; core_addr = 7'd10; core_wdata = 8'h77;
        #1 chk("ov_core_gnt", core_gnt, 1'b1);
        tick(1);
        core_req = 1'b0;
        chk("ov_pre", ovf, 1'b0);
        tick(1);
        exp_regs[10] = 8'h77;
        exp_regs[8]  = 8'h11;
        chk("ov_set", ovf, 1'b1);
        chk("ov_cnt", frame_cnt, 8'd7);
        chk("ov_bank", regs_flat, exp_flat());
        end_frame();
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ov_clr", ovf, 1'b0);

        // frame counter wraps
        for (int f = 0; f < 249; f++) begin
            start_frame(7'd0, 8'h00, 1'b0);
            tick(3);
            end_frame();
        end
        chk("wrap_cnt", frame_cnt, 8'd0);

        // reset while a write is pending
        start_frame(7'd1, 8'h99, 1'b1);
        tick(3);
        rst_n = 1'b0;
        spi_done = 1'b0;
        #1;
        chk("mr_bank", regs_flat, 128'h0);
        chk("mr_cnt", frame_cnt, 8'd0);
        chk("mr_rdata", spi_rdata, 8'h00);
        chk("mr_ovf", ovf, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("mr_no_write", regs_flat, 128'h0);
        chk("mr_cnt_after", frame_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
